// File: rtl/conv_layer_sched_pkg.sv
// Shared constants and helpers for the CONV layer scheduler.
package conv_layer_sched_pkg;

  localparam int unsigned DEF_IMG_W  = 64;
  localparam int unsigned DEF_ADDR_W = 12;

  // FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_POOL = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Memory select codes
  localparam logic [2:0] CSEL_NONE = 3'b000;
  localparam logic [2:0] CSEL_L0   = 3'b001;
  localparam logic [2:0] CSEL_L1   = 3'b011;

  localparam int unsigned CONV_CYC = 11;
  localparam int unsigned POOL_CYC = 6;
  localparam int unsigned NUM_TAPS = 9;

  // Row offset of a 3x3 tap as 2-bit two's complement (-1, 0, +1).
  function automatic logic [1:0] tap_dy(input logic [3:0] tap);
    case (tap)
      4'd0, 4'd1, 4'd2: tap_dy = 2'b11;
      4'd6, 4'd7, 4'd8: tap_dy = 2'b01;
      default:          tap_dy = 2'b00;
    endcase
  endfunction

  // Column offset of a 3x3 tap as 2-bit two's complement (-1, 0, +1).
  function automatic logic [1:0] tap_dx(input logic [3:0] tap);
    case (tap)
      4'd0, 4'd3, 4'd6: tap_dx = 2'b11;
      4'd2, 4'd5, 4'd8: tap_dx = 2'b01;
      default:          tap_dx = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/conv_layer_sched_if.sv
// Control/memory bus between the scheduler and the image/L0/L1 memories and datapath.
interface conv_layer_sched_if
  import conv_layer_sched_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
);
  logic              ready;
  logic              busy;
  logic [ADDR_W-1:0] iaddr;
  logic              crd;
  logic [ADDR_W-1:0] caddr_rd;
  logic              cwr;
  logic [ADDR_W-1:0] caddr_wr;
  logic [2:0]        csel;
  logic              dp_clr;
  logic              dp_mac_en;
  logic [3:0]        dp_tap;
  logic              dp_pad;
  logic              dp_pool_en;

  modport master (
    input  ready,
    output busy, iaddr, crd, caddr_rd, cwr, caddr_wr, csel,
    output dp_clr, dp_mac_en, dp_tap, dp_pad, dp_pool_en
  );

  modport slave (
    output ready,
    input  busy, iaddr, crd, caddr_rd, cwr, caddr_wr, csel,
    input  dp_clr, dp_mac_en, dp_tap, dp_pad, dp_pool_en
  );
endinterface

// File: rtl/conv_layer_sched_win_addr_gen.sv
// 3x3 window address generator: clamps the tap coordinate into the image and flags padding.
module conv_layer_sched_win_addr_gen
  import conv_layer_sched_pkg::*;
#(
  parameter int unsigned COORD_W = 6
) (
  input  logic [COORD_W-1:0]   row,
  input  logic [COORD_W-1:0]   col,
  input  logic [3:0]           tap,
  output logic [2*COORD_W-1:0] addr,
  output logic                 pad
);

  logic [1:0]         dy;
  logic [1:0]         dx;
  logic [COORD_W+1:0] row_s;
  logic [COORD_W+1:0] col_s;
  logic [COORD_W-1:0] row_c;
  logic [COORD_W-1:0] col_c;

  // Two guard bits: the MSB flags -1 (underflow), the next flags IMG_W (overflow).
  always_comb begin
    dy    = tap_dy(tap);
    dx    = tap_dx(tap);
    row_s = {2'b00, row} + {{COORD_W{dy[1]}}, dy};
    col_s = {2'b00, col} + {{COORD_W{dx[1]}}, dx};

    if (row_s[COORD_W+1])    row_c = '0;
    else if (row_s[COORD_W]) row_c = '1;
    else                     row_c = row_s[COORD_W-1:0];

    if (col_s[COORD_W+1])    col_c = '0;
    else if (col_s[COORD_W]) col_c = '1;
    else                     col_c = col_s[COORD_W-1:0];

    pad  = row_s[COORD_W+1] | row_s[COORD_W] | col_s[COORD_W+1] | col_s[COORD_W];
    addr = {row_c, col_c};
  end

endmodule

// File: rtl/conv_layer_sched.sv
// CONV engine scheduler: 3x3 padded conv into L0, then 2x2 stride-2 max-pool into L1.
module conv_layer_sched
  import conv_layer_sched_pkg::*;
#(
  parameter int unsigned IMG_W  = DEF_IMG_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input logic              clk,
  input logic              reset,
  conv_layer_sched_if.master bus
);

  localparam int unsigned COORD_W = $clog2(IMG_W);
  localparam int unsigned POOL_W  = ADDR_W - 2;

  localparam logic [3:0] CONV_LAST = 4'(CONV_CYC - 1);
  localparam logic [3:0] POOL_LAST = 4'(POOL_CYC - 1);
  localparam logic [3:0] TAP_LAST  = 4'(NUM_TAPS - 1);

  logic [1:0]        state_q, state_d;
  logic [3:0]        phase_q, phase_d;
  logic [ADDR_W-1:0] pix_q, pix_d;
  logic [POOL_W-1:0] pool_q, pool_d;
  logic              pad_q, pad_d;

  logic [3:0]         win_tap;
  logic [ADDR_W-1:0]  win_addr;
  logic               win_pad;
  logic [COORD_W-2:0] pool_row;
  logic [COORD_W-2:0] pool_col;

  // Window generator follows the read tap; phases 9/10 park on the last tap.
  always_comb begin
    win_tap  = (phase_q <= TAP_LAST) ? phase_q : TAP_LAST;
    pool_row = pool_q[POOL_W-1:COORD_W-1];
    pool_col = pool_q[COORD_W-2:0];
    pad_d    = (state_q == ST_CONV) && win_pad;
  end

  conv_layer_sched_win_addr_gen #(
    .COORD_W (COORD_W)
  ) u_win_addr_gen (
    .row  (pix_q[ADDR_W-1:COORD_W]),
    .col  (pix_q[COORD_W-1:0]),
    .tap  (win_tap),
    .addr (win_addr),
    .pad  (win_pad)
  );

  // Next-state: FSM, phase counter and pixel/pool counters.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    pix_d   = pix_q;
    pool_d  = pool_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.ready) begin
          state_d = ST_CONV;
          phase_d = '0;
          pix_d   = '0;
          pool_d  = '0;
        end
      end
      ST_CONV: begin
        if (phase_q == CONV_LAST) begin
          phase_d = '0;
          if (pix_q == '1) begin
            state_d = ST_POOL;
            pix_d   = '0;
          end else begin
            pix_d = pix_q + 1'b1;
          end
        end else begin
          phase_d = phase_q + 4'd1;
        end
      end
      ST_POOL: begin
        if (phase_q == POOL_LAST) begin
          phase_d = '0;
          if (pool_q == '1) begin
            state_d = ST_DONE;
            pool_d  = '0;
          end else begin
            pool_d = pool_q + 1'b1;
          end
        end else begin
          phase_d = phase_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset aborts any job in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      pix_q   <= '0;
      pool_q  <= '0;
      pad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      pix_q   <= pix_d;
      pool_q  <= pool_d;
      pad_q   <= pad_d;
    end
  end

  // Output decode from state and phase; pad is delayed one cycle to line up with dp_mac_en.
  always_comb begin
    bus.busy       = 1'b0;
    bus.iaddr      = '0;
    bus.crd        = 1'b0;
    bus.caddr_rd   = '0;
    bus.cwr        = 1'b0;
    bus.caddr_wr   = '0;
    bus.csel       = CSEL_NONE;
    bus.dp_clr     = 1'b0;
    bus.dp_mac_en  = 1'b0;
    bus.dp_tap     = '0;
    bus.dp_pad     = 1'b0;
    bus.dp_pool_en = 1'b0;
    case (state_q)
      ST_CONV: begin
        bus.busy   = 1'b1;
        bus.dp_clr = (phase_q == 4'd0);
        if (phase_q <= TAP_LAST) begin
          bus.iaddr = win_addr;
        end
        if (phase_q != 4'd0 && phase_q != CONV_LAST) begin
          bus.dp_mac_en = 1'b1;
          bus.dp_tap    = phase_q - 4'd1;
          bus.dp_pad    = pad_q;
        end
        if (phase_q == CONV_LAST) begin
          bus.cwr      = 1'b1;
          bus.csel     = CSEL_L0;
          bus.caddr_wr = pix_q;
        end
      end
      ST_POOL: begin
        bus.busy       = 1'b1;
        bus.dp_clr     = (phase_q == 4'd0);
        bus.dp_pool_en = (phase_q != 4'd0) && (phase_q < POOL_LAST);
        if (phase_q < 4'd4) begin
          bus.crd      = 1'b1;
          bus.csel     = CSEL_L0;
          bus.caddr_rd = {pool_row, phase_q[1], pool_col, phase_q[0]};
        end
        if (phase_q == POOL_LAST) begin
          bus.cwr      = 1'b1;
          bus.csel     = CSEL_L1;
          bus.caddr_wr = {2'b00, pool_q};
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_conv_layer_sched.sv
// Scoreboard bench for conv_layer_sched: a per-cycle reference stream built from the
// conv/pool rules is queued at job start and checked by an independent monitor.
module tb_conv_layer_sched;

  localparam int W    = 64;
  localparam int NPIX = W * W;
  localparam int NPOOL = NPIX / 4;
  localparam int JOB_CYC = NPIX * 11 + NPOOL * 6;

  typedef struct {
    logic [11:0] iaddr;
    logic        ia_care;
    logic        crd;
    logic [11:0] caddr_rd;
    logic        cwr;
    logic [11:0] caddr_wr;
    logic [2:0]  csel;
    logic        clr;
    logic        mac;
    logic [3:0]  tap;
    logic        pad;
    logic        pool_en;
  } rec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  conv_layer_sched_if #(.ADDR_W(12)) bus ();

  conv_layer_sched #(.IMG_W(64), .ADDR_W(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  rec_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   busy_cnt = 0;
  int   l0_cnt[NPIX];
  int   l1_cnt[NPOOL];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic int clampc(input int v);
    if (v < 0) return 0;
    if (v > W - 1) return W - 1;
    return v;
  endfunction

  // Reference stream for one full job, one record per busy cycle.
  task automatic push_job();
    rec_t r;
    for (int p = 0; p < NPIX; p++) begin
      int row = p / W;
      int col = p % W;
      for (int k = 0; k < 11; k++) begin
        r = '{default: '0};
        r.clr = (k == 0);
        if (k <= 8) begin
          r.iaddr   = 12'(clampc(row + k / 3 - 1) * W + clampc(col + k % 3 - 1));
          r.ia_care = 1'b1;
        end
        if (k >= 1 && k <= 9) begin
          int t = k - 1;
          int ry = row + t / 3 - 1;
          int cx = col + t % 3 - 1;
          r.mac = 1'b1;
          r.tap = 4'(t);
          r.pad = (ry < 0 || ry >= W || cx < 0 || cx >= W);
        end
        if (k == 10) begin
          r.cwr      = 1'b1;
          r.csel     = 3'b001;
          r.caddr_wr = 12'(p);
        end
        exp_q.push_back(r);
      end
    end
    for (int q = 0; q < NPOOL; q++) begin
      int i = q / (W / 2);
      int j = q % (W / 2);
      for (int k = 0; k < 6; k++) begin
        r = '{default: '0};
        r.clr     = (k == 0);
        r.pool_en = (k >= 1 && k <= 4);
        if (k < 4) begin
          r.crd      = 1'b1;
          r.csel     = 3'b001;
          r.caddr_rd = 12'((2 * i + k / 2) * W + 2 * j + k % 2);
        end
        if (k == 5) begin
          r.cwr      = 1'b1;
          r.csel     = 3'b011;
          r.caddr_wr = 12'(q);
        end
        exp_q.push_back(r);
      end
    end
  endtask

  // Monitor: invariants every cycle, one reference record per busy cycle.
  initial begin
    rec_t r;
    forever begin
      @(negedge clk);
      check("rd_wr_exclusive", {31'b0, bus.crd & bus.cwr}, 0);
      if (!bus.crd && !bus.cwr) check("csel_idle", {29'b0, bus.csel}, 0);
      if (bus.cwr) begin
        if (bus.csel == 3'b001) l0_cnt[bus.caddr_wr]++;
        else if (bus.csel == 3'b011 && bus.caddr_wr < 12'(NPOOL)) l1_cnt[bus.caddr_wr]++;
      end
      if (bus.busy) begin
        busy_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_busy", 1, 0);
        end else begin
          r = exp_q.pop_front();
          check("crd", {31'b0, bus.crd}, {31'b0, r.crd});
          check("cwr", {31'b0, bus.cwr}, {31'b0, r.cwr});
          check("csel", {29'b0, bus.csel}, {29'b0, r.csel});
          check("dp_clr", {31'b0, bus.dp_clr}, {31'b0, r.clr});
          check("dp_mac_en", {31'b0, bus.dp_mac_en}, {31'b0, r.mac});
          check("dp_pool_en", {31'b0, bus.dp_pool_en}, {31'b0, r.pool_en});
          if (r.ia_care) check("iaddr", {20'b0, bus.iaddr}, {20'b0, r.iaddr});
          if (r.crd) check("caddr_rd", {20'b0, bus.caddr_rd}, {20'b0, r.caddr_rd});
          if (r.cwr) check("caddr_wr", {20'b0, bus.caddr_wr}, {20'b0, r.caddr_wr});
          if (r.mac) begin
            check("dp_tap", {28'b0, bus.dp_tap}, {28'b0, r.tap});
            check("dp_pad", {31'b0, bus.dp_pad}, {31'b0, r.pad});
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    int off;
    int guard;
    int bad;
    bus.ready = 1'b0;

    // Held in reset with ready toggling: nothing may start.
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      bus.ready = 1'($urandom);
      #1;
      check("rst_busy", {31'b0, bus.busy}, 0);
      check("rst_cwr", {31'b0, bus.cwr}, 0);
      check("rst_crd", {31'b0, bus.crd}, 0);
      check("rst_csel", {29'b0, bus.csel}, 0);
    end
    bus.ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // Job A: aborted by reset during pixel 100.
    repeat ($urandom_range(1, 5)) @(negedge clk);
    busy_cnt = 0;
    push_job();
    bus.ready = 1'b1;
    off = $urandom_range(0, 10);
    guard = 0;
    while (busy_cnt != 100 * 11 + 1 + off && guard < 2000) begin
      @(negedge clk);
      bus.ready = 1'($urandom);
      #1;
      guard++;
    end
    check("abort_reached", {31'b0, busy_cnt == 100 * 11 + 1 + off}, 1);
    #1;
    reset = 1'b0;
    exp_q.delete();
    bus.ready = 1'b0;
    #1;
    check("abort_busy", {31'b0, bus.busy}, 0);
    check("abort_iaddr", {20'b0, bus.iaddr}, 0);
    check("abort_crd", {31'b0, bus.crd}, 0);
    check("abort_caddr_rd", {20'b0, bus.caddr_rd}, 0);
    check("abort_cwr", {31'b0, bus.cwr}, 0);
    check("abort_caddr_wr", {20'b0, bus.caddr_wr}, 0);
    check("abort_csel", {29'b0, bus.csel}, 0);
    check("abort_dp_clr", {31'b0, bus.dp_clr}, 0);
    check("abort_dp_mac_en", {31'b0, bus.dp_mac_en}, 0);
    check("abort_dp_tap", {28'b0, bus.dp_tap}, 0);
    check("abort_dp_pad", {31'b0, bus.dp_pad}, 0);
    check("abort_dp_pool_en", {31'b0, bus.dp_pool_en}, 0);
    repeat (3) @(negedge clk);
    #1;
    reset = 1'b1;

    // Job B: complete run from pixel 0.
    repeat ($urandom_range(2, 6)) @(negedge clk);
    check("idle_after_abort", {31'b0, bus.busy}, 0);
    for (int a = 0; a < NPIX; a++) l0_cnt[a] = 0;
    for (int a = 0; a < NPOOL; a++) l1_cnt[a] = 0;
    busy_cnt = 0;
    push_job();
    bus.ready = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < JOB_CYC + 100) begin
      @(negedge clk);
      bus.ready = (exp_q.size() > 20) ? 1'($urandom) : 1'b0;
      #1;
      guard++;
    end
    check("job_drained", exp_q.size(), 0);
    @(negedge clk);
    #1;
    check("done_busy_low", {31'b0, bus.busy}, 0);
    repeat (3) @(negedge clk);
    #1;
    check("stays_idle", {31'b0, bus.busy}, 0);
    check("busy_cycles", busy_cnt, JOB_CYC);
    bad = 0;
    for (int a = 0; a < NPIX; a++) if (l0_cnt[a] != 1) bad++;
    check("l0_each_once", bad, 0);
    bad = 0;
    for (int a = 0; a < NPOOL; a++) if (l1_cnt[a] != 1) bad++;
    check("l1_each_once", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
